// File: rtl/clk_pkg.sv
// Shared definitions for the clock user-interface controller.
// Holds the mode and cursor-field encodings, the field limits, and the
// calendar helpers used to step and clamp the staged time values.
package clk_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL    = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2
  } mode_t;

  // Cursor positions. Alarm editing only uses SEC..HOUR.
  localparam logic [2:0] FIELD_SEC   = 3'd0;
  localparam logic [2:0] FIELD_MIN   = 3'd1;
  localparam logic [2:0] FIELD_HOUR  = 3'd2;
  localparam logic [2:0] FIELD_DAY   = 3'd3;
  localparam logic [2:0] FIELD_MONTH = 3'd4;
  localparam logic [2:0] FIELD_YEAR  = 3'd5;

  localparam logic [2:0] TIME_FIELD_LAST  = FIELD_YEAR;
  localparam logic [2:0] ALARM_FIELD_LAST = FIELD_HOUR;

  localparam logic [15:0] SEC_MAX   = 16'd59;
  localparam logic [15:0] HOUR_MAX  = 16'd23;
  localparam logic [15:0] MONTH_MAX = 16'd12;

  function automatic logic is_leap(input logic [15:0] year);
    return ((year % 16'd4) == 16'd0) &&
           (((year % 16'd100) != 16'd0) || ((year % 16'd400) == 16'd0));
  endfunction

  // Gregorian days in month; out-of-range months fall back to 31.
  function automatic logic [15:0] days_in_month(input logic [5:0] month,
                                                input logic [15:0] year);
    case (month)
      6'd2:                      return is_leap(year) ? 16'd29 : 16'd28;
      6'd4, 6'd6, 6'd9, 6'd11:   return 16'd30;
      default:                   return 16'd31;
    endcase
  endfunction

  // One step up or down with wrap inside [lo, hi]. Values already outside
  // the range (e.g. a bad live snapshot) wrap as if they sat on the bound.
  function automatic logic [15:0] step_wrap(input logic [15:0] v,
                                            input logic [15:0] lo,
                                            input logic [15:0] hi,
                                            input logic        inc);
    if (inc) return (v >= hi) ? lo : v + 16'd1;
    else     return (v <= lo) ? hi : v - 16'd1;
  endfunction

  function automatic logic [15:0] clamp_max(input logic [15:0] v,
                                            input logic [15:0] hi);
    return (v > hi) ? hi : v;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Button conditioner: 2-FF synchronizer followed by a rising-edge detector.
// Ports:
//   clk, rst  - system clock, asynchronous active-high reset
//   pin       - debounced button level, asynchronous to clk
//   rise      - one-cycle pulse on the second clk edge after pin goes high
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic rise
);

  logic sync0;
  logic sync1;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync0 <= pin;
      sync1 <= sync0;
      prev  <= sync1;
    end
  end

  assign rise = sync1 & ~prev;

endmodule

// File: rtl/mode_ctrl.sv
// User-interface controller for the clock. Turns five buttons into a
// NORMAL / SET_TIME / SET_ALARM state machine that snapshots the live time,
// edits it field by field with calendar wrap rules, commits it with a
// one-cycle time_load strobe, and stages/commits the alarm.
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   sec_tick                     - one-cycle pulse per second (idle timeout)
//   up, down, left, right, middle- debounced button levels (async)
//   cur_*                        - live time from the time counter
//   mode, field                  - FSM state and cursor position
//   edit_*                       - staged time values
//   time_load                    - one-cycle strobe: counter loads edit_*
//   alarm_hour/minute/second     - committed alarm time
//   alarm_en                     - alarm armed
//   alarm_mode                   - 0 normal, field+1 while editing the alarm
module mode_ctrl
  import clk_pkg::*;
#(
  parameter int YEAR_MIN     = 2000,
  parameter int YEAR_MAX     = 2099,
  parameter int IDLE_TIMEOUT = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sec_tick,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        middle,
  input  logic [15:0] cur_year,
  input  logic [5:0]  cur_month,
  input  logic [10:0] cur_day,
  input  logic [10:0] cur_hour,
  input  logic [10:0] cur_minute,
  input  logic [10:0] cur_second,
  output logic [1:0]  mode,
  output logic [2:0]  field,
  output logic [15:0] edit_year,
  output logic [5:0]  edit_month,
  output logic [10:0] edit_day,
  output logic [10:0] edit_hour,
  output logic [10:0] edit_minute,
  output logic [10:0] edit_second,
  output logic        time_load,
  output logic [10:0] alarm_hour,
  output logic [10:0] alarm_minute,
  output logic [10:0] alarm_second,
  output logic        alarm_en,
  output logic [2:0]  alarm_mode
);

  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [15:0] YMIN = 16'(YEAR_MIN);
  localparam logic [15:0] YMAX = 16'(YEAR_MAX);

  mode_t             state;
  logic [IDLE_W-1:0] idle_cnt;

  // Button edges
  logic e_up, e_down, e_left, e_right, e_mid;

  btn_edge u_up    (.clk(clk), .rst(rst), .pin(up),     .rise(e_up));
  btn_edge u_down  (.clk(clk), .rst(rst), .pin(down),   .rise(e_down));
  btn_edge u_left  (.clk(clk), .rst(rst), .pin(left),   .rise(e_left));
  btn_edge u_right (.clk(clk), .rst(rst), .pin(right),  .rise(e_right));
  btn_edge u_mid   (.clk(clk), .rst(rst), .pin(middle), .rise(e_mid));

  // Priority middle > left > right > up > down; losers are dropped.
  logic act_mid, act_left, act_right, act_up, act_down, act_any;

  always_comb begin
    act_mid   = e_mid;
    act_left  = e_left  & ~e_mid;
    act_right = e_right & ~e_mid & ~e_left;
    act_up    = e_up    & ~e_mid & ~e_left & ~e_right;
    act_down  = e_down  & ~e_mid & ~e_left & ~e_right & ~e_up;
    act_any   = e_mid | e_left | e_right | e_up | e_down;
  end

  // Candidate values for an up/down step on each field. The day clamps
  // cover a month or year step landing on a shorter month.
  logic [10:0] sec_step, min_step, hour_step, day_step;
  logic [5:0]  month_step;
  logic [15:0] year_step;
  logic [10:0] day_after_month, day_after_year;

  always_comb begin
    sec_step   = 11'(step_wrap({5'd0, edit_second}, 16'd0, SEC_MAX, act_up));
    min_step   = 11'(step_wrap({5'd0, edit_minute}, 16'd0, SEC_MAX, act_up));
    hour_step  = 11'(step_wrap({5'd0, edit_hour}, 16'd0, HOUR_MAX, act_up));
    day_step   = 11'(step_wrap({5'd0, edit_day}, 16'd1,
                               days_in_month(edit_month, edit_year), act_up));
    month_step = 6'(step_wrap({10'd0, edit_month}, 16'd1, MONTH_MAX, act_up));
    year_step  = step_wrap(edit_year, YMIN, YMAX, act_up);
    day_after_month = 11'(clamp_max({5'd0, edit_day},
                                    days_in_month(month_step, edit_year)));
    day_after_year  = 11'(clamp_max({5'd0, edit_day},
                                    days_in_month(edit_month, year_step)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= MODE_NORMAL;
      field        <= FIELD_SEC;
      edit_year    <= YMIN;
      edit_month   <= 6'd1;
      edit_day     <= 11'd1;
      edit_hour    <= '0;
      edit_minute  <= '0;
      edit_second  <= '0;
      time_load    <= 1'b0;
      alarm_hour   <= '0;
      alarm_minute <= '0;
      alarm_second <= '0;
      alarm_en     <= 1'b0;
      idle_cnt     <= '0;
    end else begin
      time_load <= 1'b0;
      if (time_load) begin
        // The strobe cycle kept the committed time on edit_*; now preload
        // the alarm for editing. A button edge in this cycle is dropped.
        edit_hour   <= alarm_hour;
        edit_minute <= alarm_minute;
        edit_second <= alarm_second;
      end else if (act_any) begin
        idle_cnt <= '0;
        case (state)
          MODE_NORMAL: begin
            if (act_mid) begin
              edit_year   <= cur_year;
              edit_month  <= cur_month;
              edit_day    <= cur_day;
              edit_hour   <= cur_hour;
              edit_minute <= cur_minute;
              edit_second <= cur_second;
              field       <= FIELD_SEC;
              state       <= MODE_SET_TIME;
            end else if (act_up) begin
              alarm_en <= ~alarm_en;
            end
          end

          MODE_SET_TIME: begin
            if (act_mid) begin
              time_load <= 1'b1;
              field     <= FIELD_SEC;
              state     <= MODE_SET_ALARM;
            end else if (act_left) begin
              field <= (field >= TIME_FIELD_LAST) ? FIELD_SEC : field + 3'd1;
            end else if (act_right) begin
              field <= (field == FIELD_SEC) ? TIME_FIELD_LAST : field - 3'd1;
            end else if (act_up || act_down) begin
              case (field)
                FIELD_SEC:   edit_second <= sec_step;
                FIELD_MIN:   edit_minute <= min_step;
                FIELD_HOUR:  edit_hour   <= hour_step;
                FIELD_DAY:   edit_day    <= day_step;
                FIELD_MONTH: begin
                  edit_month <= month_step;
                  edit_day   <= day_after_month;
                end
                FIELD_YEAR: begin
                  edit_year <= year_step;
                  edit_day  <= day_after_year;
                end
                default: ;
              endcase
            end
          end

          MODE_SET_ALARM: begin
            if (act_mid) begin
              alarm_hour   <= edit_hour;
              alarm_minute <= edit_minute;
              alarm_second <= edit_second;
              alarm_en     <= 1'b1;
              field        <= FIELD_SEC;
              state        <= MODE_NORMAL;
            end else if (act_left) begin
              field <= (field >= ALARM_FIELD_LAST) ? FIELD_SEC : field + 3'd1;
            end else if (act_right) begin
              field <= (field == FIELD_SEC) ? ALARM_FIELD_LAST : field - 3'd1;
            end else if (act_up || act_down) begin
              case (field)
                FIELD_SEC:  edit_second <= sec_step;
                FIELD_MIN:  edit_minute <= min_step;
                FIELD_HOUR: edit_hour   <= hour_step;
                default: ;
              endcase
            end
          end

          default: begin
            state <= MODE_NORMAL;
            field <= FIELD_SEC;
          end
        endcase
      end else if (state != MODE_NORMAL) begin
        // Idle timeout: abandon the edit, no strobe, alarm untouched.
        if (sec_tick) begin
          if (idle_cnt >= IDLE_LAST) begin
            state    <= MODE_NORMAL;
            field    <= FIELD_SEC;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  assign mode       = state;
  assign alarm_mode = (state == MODE_SET_ALARM) ? field + 3'd1 : 3'd0;

endmodule
